// File: rtl/bus_ctrl.sv
// CPU bus controller: decodes requests into ROM / RAM / IO / unmapped regions,
// applies per-region wait states and completes each access with a one-cycle done pulse.
module bus_ctrl #(
  parameter int          ROM_ADDR_BITS = 8,
  parameter int          RAM_ADDR_BITS = 6,
  parameter logic [15:0] RAM_BASE      = 16'hC000,
  parameter logic [15:0] IO_BASE       = 16'hFF00,
  parameter int          ROM_WAIT      = 1,
  parameter int          RAM_WAIT      = 0,
  parameter int          GPIO_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [15:0]              bus_address,
  input  logic [7:0]               bus_wdata,
  input  logic                     bus_read,
  input  logic                     bus_write,
  output logic [7:0]               bus_rdata,
  output logic                     bus_done,
  output logic [ROM_ADDR_BITS-1:0] rom_addr,
  input  logic [7:0]               rom_data,
  output logic [7:0]               spi_data_tx,
  output logic                     spi_have_data,
  input  logic [7:0]               spi_data_rx,
  input  logic                     spi_txn_done,
  output logic [GPIO_WIDTH-1:0]    gpio_out,
  input  logic [GPIO_WIDTH-1:0]    gpio_in,
  output logic [1:0]               dbg_state_o
);

  // Handshake: bus_read/bus_write are level requests the cpu holds until it sees
  // bus_done; bus_done is a one-cycle acknowledge and bus_rdata is valid with it.
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  typedef enum logic [1:0] {R_ROM, R_RAM, R_IO, R_NONE} region_t;

  localparam logic [3:0] ROM_WAIT_C = 4'(ROM_WAIT);
  localparam logic [3:0] RAM_WAIT_C = 4'(RAM_WAIT);

  state_t                   state_q;
  region_t                  region_q;
  region_t                  req_region;
  logic [3:0]               req_wait;
  logic [RAM_ADDR_BITS-1:0] addr_q;
  logic [7:0]               wdata_q;
  logic                     is_read_q;
  logic [3:0]               cnt_q;
  logic                     done_q;
  logic [7:0]               rdata_q;
  logic [ROM_ADDR_BITS-1:0] rom_addr_q;
  logic [7:0]               spi_tx_q;
  logic                     spi_have_q;
  logic [7:0]               rx_q;
  logic                     rx_valid_q;
  logic                     overrun_q;
  logic [GPIO_WIDTH-1:0]    gpio_q;
  logic [7:0]               mem_q [2**RAM_ADDR_BITS];
  logic                     access;
  logic                     ram_we;
  logic [7:0]               gpio_out_ext;
  logic [7:0]               gpio_in_ext;
  logic [7:0]               io_rdata;

  // Priority IO > RAM > ROM when windows overlap.
  always_comb begin
    req_region = R_NONE;
    req_wait   = 4'd0;
    if (bus_address[15:2] == IO_BASE[15:2]) begin
      req_region = R_IO;
    end else if (bus_address[15:RAM_ADDR_BITS] == RAM_BASE[15:RAM_ADDR_BITS]) begin
      req_region = R_RAM;
      req_wait   = RAM_WAIT_C;
    end else if (bus_address[15:ROM_ADDR_BITS] == '0) begin
      req_region = R_ROM;
      req_wait   = ROM_WAIT_C;
    end
  end

  assign access = (state_q == S_ACCESS) && (cnt_q == 4'd0);
  assign ram_we = access && !is_read_q && (region_q == R_RAM);

  always_comb begin
    gpio_out_ext                 = 8'h00;
    gpio_out_ext[GPIO_WIDTH-1:0] = gpio_q;
    gpio_in_ext                  = 8'h00;
    gpio_in_ext[GPIO_WIDTH-1:0]  = gpio_in;
    case (addr_q[1:0])
      2'd0:    io_rdata = rx_q;
      2'd1:    io_rdata = {5'b0, overrun_q, rx_valid_q, spi_have_q};
      2'd2:    io_rdata = gpio_out_ext;
      default: io_rdata = gpio_in_ext;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      region_q   <= R_NONE;
      addr_q     <= '0;
      wdata_q    <= 8'h00;
      is_read_q  <= 1'b0;
      cnt_q      <= 4'd0;
      done_q     <= 1'b0;
      rdata_q    <= 8'h00;
      rom_addr_q <= '0;
      spi_tx_q   <= 8'h00;
      spi_have_q <= 1'b0;
      rx_q       <= 8'h00;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      gpio_q     <= '0;
    end else begin
      done_q <= 1'b0;
      // Receive side runs independently; bus accesses below may override it.
      if (spi_txn_done) begin
        rx_q       <= spi_data_rx;
        rx_valid_q <= 1'b1;
        spi_have_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (bus_read || bus_write) begin
            addr_q    <= bus_address[RAM_ADDR_BITS-1:0];
            wdata_q   <= bus_wdata;
            is_read_q <= bus_read;
            region_q  <= req_region;
            cnt_q     <= req_wait;
            if (req_region == R_ROM && bus_read) begin
              rom_addr_q <= bus_address[ROM_ADDR_BITS-1:0];
            end
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_DONE;
            if (is_read_q) begin
              case (region_q)
                R_ROM:   rdata_q <= rom_data;
                R_RAM:   rdata_q <= mem_q[addr_q];
                R_IO:    rdata_q <= io_rdata;
                default: rdata_q <= 8'h00;
              endcase
              if (region_q == R_IO && addr_q[1:0] == 2'd0 && !spi_txn_done) begin
                rx_valid_q <= 1'b0;
              end
              if (region_q == R_IO && addr_q[1:0] == 2'd1) begin
                overrun_q <= 1'b0;
              end
            end else if (region_q == R_IO) begin
              // A completing transfer frees the tx slot in the same cycle.
              if (addr_q[1:0] == 2'd0) begin
                if (spi_have_q && !spi_txn_done) begin
                  overrun_q <= 1'b1;
                end else begin
                  spi_tx_q   <= wdata_q;
                  spi_have_q <= 1'b1;
                end
              end else if (addr_q[1:0] == 2'd2) begin
                gpio_q <= wdata_q[GPIO_WIDTH-1:0];
              end
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Contents are not reset; a write aborted by reset never reaches the array.
  always_ff @(posedge clk) begin
    if (rst_n && ram_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign bus_done      = done_q;
  assign bus_rdata     = rdata_q;
  assign rom_addr      = rom_addr_q;
  assign spi_data_tx   = spi_tx_q;
  assign spi_have_data = spi_have_q;
  assign gpio_out      = gpio_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_bus_ctrl.sv
// Bench for bus_ctrl: directed vector table, hand-timed SPI/reset corner cases,
// and randomized traffic checked against a region-level reference model.
module tb_bus_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wd0, wd1;
  logic        rd0, rd1, wr0, wr1;
  logic [7:0]  rdata0, rdata1;
  logic        done0, done1;
  logic [7:0]  rom_addr0, rom_addr1, rom_data0, rom_data1;
  logic [7:0]  tx0, tx1;
  logic        have0, have1;
  logic [3:0]  gpio0, gpio1;
  logic [1:0]  dbg0, dbg1;
  logic [7:0]  spi_data_rx;
  logic        spi_txn_done;
  logic [3:0]  gpio_in;
  logic [7:0]  rom_image [256];

  bus_ctrl #(.ROM_WAIT(1), .RAM_WAIT(0), .GPIO_WIDTH(4)) dut0 (
    .clk(clk), .rst_n(rst0), .bus_address(addr0), .bus_wdata(wd0),
    .bus_read(rd0), .bus_write(wr0), .bus_rdata(rdata0), .bus_done(done0),
    .rom_addr(rom_addr0), .rom_data(rom_data0), .spi_data_tx(tx0),
    .spi_have_data(have0), .spi_data_rx(spi_data_rx), .spi_txn_done(spi_txn_done),
    .gpio_out(gpio0), .gpio_in(gpio_in), .dbg_state_o(dbg0));

  bus_ctrl #(.ROM_WAIT(2), .RAM_WAIT(3), .GPIO_WIDTH(4)) dut1 (
    .clk(clk), .rst_n(rst1), .bus_address(addr1), .bus_wdata(wd1),
    .bus_read(rd1), .bus_write(wr1), .bus_rdata(rdata1), .bus_done(done1),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .spi_data_tx(tx1),
    .spi_have_data(have1), .spi_data_rx(spi_data_rx), .spi_txn_done(spi_txn_done),
    .gpio_out(gpio1), .gpio_in(gpio_in), .dbg_state_o(dbg1));

  // Synchronous ROMs: data follows the address by one clock.
  always @(posedge clk) rom_data0 <= rom_image[rom_addr0];
  always @(posedge clk) rom_data1 <= rom_image[rom_addr1];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input bit rd, input bit wr, input logic [15:0] a,
                       input logic [7:0] wd);
    if (d == 0) begin rd0 = rd; wr0 = wr; addr0 = a; wd0 = wd; end
    else        begin rd1 = rd; wr1 = wr; addr1 = a; wd1 = wd; end
  endtask

  function automatic logic get_done(input int d);
    return (d == 0) ? done0 : done1;
  endfunction

  // Called just after a falling edge; returns at the falling edge where done is seen.
  // lat counts rising edges after the sampling edge until done is visible.
  task automatic bus_op(input int d, input bit rd, input bit wr, input logic [15:0] a,
                        input logic [7:0] wd, output logic [7:0] got, output int lat);
    drive(d, rd, wr, a, wd);
    @(posedge clk);
    #1 drive(d, rd, wr, 16'($urandom), 8'($urandom));
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (get_done(d)) break;
    end
    got = (d == 0) ? rdata0 : rdata1;
    drive(d, 1'b0, 1'b0, 16'($urandom), 8'($urandom));
  endtask

  task automatic pulse_txn(input logic [7:0] rx);
    spi_data_rx  = rx;
    spi_txn_done = 1'b1;
    @(negedge clk);
    spi_txn_done = 1'b0;
  endtask

  // Reference model for dut0 (ROM_WAIT=1, RAM_WAIT=0, GPIO_WIDTH=4)
  logic [7:0] m_ram [64];
  logic [7:0] m_rdata, m_tx, m_rx, m_ra;
  logic       m_have, m_ovr, m_rxv;
  logic [3:0] m_gpio;

  task automatic model_reset();
    m_rdata = 0; m_tx = 0; m_rx = 0; m_ra = 0;
    m_have = 0; m_ovr = 0; m_rxv = 0; m_gpio = 0;
  endtask

  task automatic model_op(input bit rd, input bit wr, input logic [15:0] a,
                          input logic [7:0] wd, output logic [7:0] exp_rd, output int exp_lat);
    exp_lat = 2;
    if (a >= 16'hFF00) begin
      if (a <= 16'hFF03) begin
        case (a - 16'hFF00)
          16'd0: if (rd) begin m_rdata = m_rx; m_rxv = 0; end
                 else if (wr) begin
                   if (m_have) m_ovr = 1;
                   else begin m_tx = wd; m_have = 1; end
                 end
          16'd1: if (rd) begin m_rdata = {5'b0, m_ovr, m_rxv, m_have}; m_ovr = 0; end
          16'd2: if (rd) m_rdata = {4'b0, m_gpio}; else if (wr) m_gpio = wd[3:0];
          default: if (rd) m_rdata = {4'b0, gpio_in};
        endcase
      end else if (rd) m_rdata = 8'h00;
    end else if (a >= 16'hC000 && a < 16'hC040) begin
      if (rd) m_rdata = m_ram[a - 16'hC000];
      else if (wr) m_ram[a - 16'hC000] = wd;
    end else if (a < 16'h0100) begin
      exp_lat = 3;
      if (rd) begin m_rdata = rom_image[a[7:0]]; m_ra = a[7:0]; end
    end else if (rd) begin
      m_rdata = 8'h00;
    end
    exp_rd = m_rdata;
  endtask

  typedef struct {
    bit          txn;
    logic [7:0]  rx;
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  exp_rd;
    int          exp_lat;
    bit          exp_have;
    logic [7:0]  exp_tx;
    logic [3:0]  exp_gpio;
    logic [7:0]  exp_ra;
  } vec_t;

  function automatic vec_t mk(bit txn, logic [7:0] rx, bit rd, bit wr, logic [15:0] a,
                              logic [7:0] wd, logic [7:0] er, int el, bit eh,
                              logic [7:0] et, logic [3:0] eg, logic [7:0] era);
    vec_t v;
    v.txn = txn; v.rx = rx; v.rd = rd; v.wr = wr; v.addr = a; v.wd = wd;
    v.exp_rd = er; v.exp_lat = el; v.exp_have = eh; v.exp_tx = et;
    v.exp_gpio = eg; v.exp_ra = era;
    return v;
  endfunction

  localparam int NV = 27;
  vec_t        tbl [NV];
  logic [7:0]  got, exp_rd;
  int          lat, exp_lat, ndone;
  logic [15:0] ra;
  logic [7:0]  rw, rv;
  bit          rrd, rwr;

  initial begin
    tbl[0]  = mk(0, 8'h00, 1, 0, 16'h0000, 8'h00, 8'h3E, 3, 0, 8'h00, 4'h0, 8'h00);
    tbl[1]  = mk(0, 8'h00, 0, 1, 16'hC005, 8'h5A, 8'h3E, 2, 0, 8'h00, 4'h0, 8'h00);
    tbl[2]  = mk(0, 8'h00, 1, 0, 16'hC005, 8'h00, 8'h5A, 2, 0, 8'h00, 4'h0, 8'h00);
    tbl[3]  = mk(0, 8'h00, 0, 1, 16'hFF00, 8'hA5, 8'h5A, 2, 1, 8'hA5, 4'h0, 8'h00);
    tbl[4]  = mk(0, 8'h00, 0, 1, 16'hFF00, 8'h77, 8'h5A, 2, 1, 8'hA5, 4'h0, 8'h00);
    tbl[5]  = mk(0, 8'h00, 1, 0, 16'hFF01, 8'h00, 8'h05, 2, 1, 8'hA5, 4'h0, 8'h00);
    tbl[6]  = mk(0, 8'h00, 1, 0, 16'hFF01, 8'h00, 8'h01, 2, 1, 8'hA5, 4'h0, 8'h00);
    tbl[7]  = mk(1, 8'h3C, 1, 0, 16'hFF01, 8'h00, 8'h02, 2, 0, 8'hA5, 4'h0, 8'h00);
    tbl[8]  = mk(0, 8'h00, 1, 0, 16'hFF00, 8'h00, 8'h3C, 2, 0, 8'hA5, 4'h0, 8'h00);
    tbl[9]  = mk(0, 8'h00, 1, 0, 16'hFF01, 8'h00, 8'h00, 2, 0, 8'hA5, 4'h0, 8'h00);
    tbl[10] = mk(0, 8'h00, 0, 1, 16'hFF02, 8'hFF, 8'h00, 2, 0, 8'hA5, 4'hF, 8'h00);
    tbl[11] = mk(0, 8'h00, 1, 0, 16'hFF02, 8'h00, 8'h0F, 2, 0, 8'hA5, 4'hF, 8'h00);
    tbl[12] = mk(0, 8'h00, 1, 0, 16'hFF03, 8'h00, 8'h09, 2, 0, 8'hA5, 4'hF, 8'h00);
    tbl[13] = mk(0, 8'h00, 1, 0, 16'h8000, 8'h00, 8'h00, 2, 0, 8'hA5, 4'hF, 8'h00);
    tbl[14] = mk(0, 8'h00, 1, 0, 16'h0025, 8'h00, 8'hC7, 3, 0, 8'hA5, 4'hF, 8'h25);
    tbl[15] = mk(0, 8'h00, 0, 1, 16'h0010, 8'hAA, 8'hC7, 3, 0, 8'hA5, 4'hF, 8'h25);
    tbl[16] = mk(0, 8'h00, 1, 0, 16'h0010, 8'h00, 8'h10, 3, 0, 8'hA5, 4'hF, 8'h10);
    tbl[17] = mk(0, 8'h00, 0, 1, 16'hC000, 8'h11, 8'h10, 2, 0, 8'hA5, 4'hF, 8'h10);
    tbl[18] = mk(0, 8'h00, 1, 1, 16'hC000, 8'hEE, 8'h11, 2, 0, 8'hA5, 4'hF, 8'h10);
    tbl[19] = mk(0, 8'h00, 1, 0, 16'hC000, 8'h00, 8'h11, 2, 0, 8'hA5, 4'hF, 8'h10);
    tbl[20] = mk(0, 8'h00, 0, 1, 16'h8000, 8'h55, 8'h11, 2, 0, 8'hA5, 4'hF, 8'h10);
    tbl[21] = mk(0, 8'h00, 0, 1, 16'hFF01, 8'hFF, 8'h11, 2, 0, 8'hA5, 4'hF, 8'h10);
    tbl[22] = mk(0, 8'h00, 1, 0, 16'hFF01, 8'h00, 8'h00, 2, 0, 8'hA5, 4'hF, 8'h10);
    tbl[23] = mk(0, 8'h00, 0, 1, 16'hFF03, 8'hFF, 8'h00, 2, 0, 8'hA5, 4'hF, 8'h10);
    tbl[24] = mk(0, 8'h00, 1, 0, 16'hFF03, 8'h00, 8'h09, 2, 0, 8'hA5, 4'hF, 8'h10);
    tbl[25] = mk(0, 8'h00, 0, 1, 16'hFF02, 8'h35, 8'h09, 2, 0, 8'hA5, 4'h5, 8'h10);
    tbl[26] = mk(0, 8'h00, 1, 0, 16'hFF02, 8'h00, 8'h05, 2, 0, 8'hA5, 4'h5, 8'h10);

    for (int i = 0; i < 256; i++) rom_image[i] = 8'($urandom);
    rom_image[8'h00] = 8'h3E;
    rom_image[8'h03] = 8'h5C;
    rom_image[8'h10] = 8'h10;
    rom_image[8'h25] = 8'hC7;

    // clock/reset
    rst0 = 0; rst1 = 0;
    drive(0, 0, 0, 16'h0, 8'h0);
    drive(1, 0, 0, 16'h0, 8'h0);
    spi_txn_done = 0; spi_data_rx = 0; gpio_in = 4'h9;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst rdata", rdata0, 8'h00);
    check("rst done", done0, 1'b0);
    check("rst rom_addr", rom_addr0, 8'h00);
    check("rst spi_tx", tx0, 8'h00);
    check("rst have", have0, 1'b0);
    check("rst gpio", gpio0, 4'h0);
    check("rst state", dbg0, 2'd0);
    rst0 = 1; rst1 = 1;
    @(negedge clk);

    // directed vector table, applied back-to-back
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].txn) pulse_txn(tbl[i].rx);
      bus_op(0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, got, lat);
      check($sformatf("v%0d rdata", i), got, tbl[i].exp_rd);
      check($sformatf("v%0d latency", i), lat, tbl[i].exp_lat);
      check($sformatf("v%0d have", i), have0, tbl[i].exp_have);
      check($sformatf("v%0d spi_tx", i), tx0, tbl[i].exp_tx);
      check($sformatf("v%0d gpio", i), gpio0, tbl[i].exp_gpio);
      check($sformatf("v%0d rom_addr", i), rom_addr0, tbl[i].exp_ra);
    end
    @(negedge clk);
    check("done one cycle", done0, 1'b0);

    // txn_done coinciding with a SPI_DATA read
    pulse_txn(8'h81);
    fork
      bus_op(0, 1, 0, 16'hFF00, 8'h00, got, lat);
      begin
        @(posedge clk);
        @(negedge clk);
        spi_data_rx = 8'h92; spi_txn_done = 1;
        @(negedge clk);
        spi_txn_done = 0;
      end
    join
    check("coinc rd old byte", got, 8'h81);
    bus_op(0, 1, 0, 16'hFF01, 8'h00, got, lat);
    check("coinc rd status", got, 8'h02);
    bus_op(0, 1, 0, 16'hFF00, 8'h00, got, lat);
    check("coinc rd new byte", got, 8'h92);
    bus_op(0, 1, 0, 16'hFF01, 8'h00, got, lat);
    check("coinc rd status2", got, 8'h00);

    // txn_done coinciding with a SPI_DATA write while busy
    bus_op(0, 0, 1, 16'hFF00, 8'h40, got, lat);
    check("coinc wr1 tx", tx0, 8'h40);
    fork
      bus_op(0, 0, 1, 16'hFF00, 8'h41, got, lat);
      begin
        @(posedge clk);
        @(negedge clk);
        spi_data_rx = 8'h17; spi_txn_done = 1;
        @(negedge clk);
        spi_txn_done = 0;
      end
    join
    check("coinc wr2 tx", tx0, 8'h41);
    check("coinc wr2 have", have0, 1'b1);
    bus_op(0, 1, 0, 16'hFF01, 8'h00, got, lat);
    check("coinc wr status", got, 8'h03);
    bus_op(0, 1, 0, 16'hFF00, 8'h00, got, lat);
    check("coinc wr rx", got, 8'h17);

    // reset during a RAM write with RAM_WAIT=3 (dut1)
    bus_op(1, 0, 1, 16'hC007, 8'h66, got, lat);
    check("d1 ram wr latency", lat, 5);
    bus_op(1, 0, 1, 16'hFF02, 8'h0C, got, lat);
    bus_op(1, 0, 1, 16'hFF00, 8'h33, got, lat);
    bus_op(1, 1, 0, 16'h0003, 8'h00, got, lat);
    check("d1 rom rdata", got, 8'h5C);
    check("d1 rom latency", lat, 4);
    check("d1 rom_addr", rom_addr1, 8'h03);
    check("d1 gpio", gpio1, 4'hC);
    check("d1 have", have1, 1'b1);
    check("d1 spi_tx", tx1, 8'h33);
    ndone = 0;
    drive(1, 0, 1, 16'hC007, 8'h99);
    @(posedge clk);
    @(negedge clk); if (done1) ndone++;
    @(negedge clk); if (done1) ndone++;
    rst1 = 0;
    drive(1, 0, 0, 16'h0000, 8'h00);
    repeat (3) begin @(negedge clk); if (done1) ndone++; end
    check("abort rdata", rdata1, 8'h00);
    check("abort rom_addr", rom_addr1, 8'h00);
    check("abort have", have1, 1'b0);
    check("abort spi_tx", tx1, 8'h00);
    check("abort gpio", gpio1, 4'h0);
    check("abort state", dbg1, 2'd0);
    rst1 = 1;
    repeat (8) begin @(negedge clk); if (done1) ndone++; end
    check("abort no done", ndone, 0);
    bus_op(1, 1, 0, 16'hC007, 8'h00, got, lat);
    check("abort ram kept", got, 8'h66);
    check("abort rd latency", lat, 5);

    // randomized traffic against the reference model
    rst0 = 0;
    repeat (2) @(negedge clk);
    check("rst2 rdata", rdata0, 8'h00);
    check("rst2 have", have0, 1'b0);
    check("rst2 gpio", gpio0, 4'h0);
    check("rst2 rom_addr", rom_addr0, 8'h00);
    rst0 = 1;
    model_reset();
    @(negedge clk);
    rv = 8'($urandom);
    pulse_txn(rv);
    m_rx = rv; m_rxv = 1; m_have = 0;
    for (int i = 0; i < 64; i++) begin
      rw = 8'($urandom);
      model_op(0, 1, 16'hC000 + 16'(i), rw, exp_rd, exp_lat);
      bus_op(0, 0, 1, 16'hC000 + 16'(i), rw, got, lat);
      check($sformatf("pre%0d latency", i), lat, exp_lat);
    end
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        rv = 8'($urandom);
        pulse_txn(rv);
        m_rx = rv; m_rxv = 1; m_have = 0;
      end
      if ($urandom_range(0, 9) == 0) gpio_in = 4'($urandom);
      case ($urandom_range(0, 4))
        0: ra = 16'($urandom_range(0, 255));
        1: ra = 16'hC000 + 16'($urandom_range(0, 63));
        2: ra = 16'hFF00 + 16'($urandom_range(0, 3));
        3: ra = 16'($urandom_range(16'h0100, 16'hBFFF));
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0, 1: begin rrd = 1; rwr = 0; end
        2, 3: begin rrd = 0; rwr = 1; end
        default: begin rrd = 1; rwr = 1; end
      endcase
      rw = 8'($urandom);
      model_op(rrd, rwr, ra, rw, exp_rd, exp_lat);
      bus_op(0, rrd, rwr, ra, rw, got, lat);
      check($sformatf("r%0d rdata @%h", i, ra), got, exp_rd);
      check($sformatf("r%0d latency @%h", i, ra), lat, exp_lat);
      check($sformatf("r%0d have", i), have0, m_have);
      check($sformatf("r%0d spi_tx", i), tx0, m_tx);
      check($sformatf("r%0d gpio", i), gpio0, m_gpio);
      check($sformatf("r%0d rom_addr", i), rom_addr0, m_ra);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
